distance_bcd_counter: RTL

DISTANCE_BCD_COUNTER -- requirements
Module: distance_bcd_counter

---
 rtl/distance_bcd_counter_if.sv | 30 +++
 rtl/distance_bcd_counter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/distance_bcd_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : distance_bcd_counter_if
// Description : Frame/race control inputs and BCD distance outputs of the
//               distance counter, bundled as one interface.
// Revision    : 1.0  initial release
// ============================================================================
interface distance_bcd_counter_if;
    logic       startOfFrame;
    logic       run;
    logic       clear;
    logic [7:0] speed;
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
    logic       distanceTick;
    logic       goalReached;

    modport master (
        output startOfFrame, run, clear, speed,
        input  thousands, hundreds, tens, units, distanceTick, goalReached
    );

    modport slave (
        input  startOfFrame, run, clear, speed,
        output thousands, hundreds, tens, units, distanceTick, goalReached
    );
endinterface
`default_nettype wire

// File: rtl/distance_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : distance_bcd_counter
// Description : Per-frame speed accumulator driving a 4-digit BCD distance
//               count with goal detection. Define DISTANCE_WRAP_EN to wrap
//               9999 -> 0000; otherwise the count saturates at 9999.
// Revision    : 1.0  initial release
// ============================================================================
module distance_bcd_counter #(
    parameter int          FRAC_MAX = 256,
    parameter logic [15:0] GOAL     = 16'h2000
) (
    input  wire logic               clk,
    input  wire logic               reset,
    distance_bcd_counter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [10:0] c_frac_max = 11'(FRAC_MAX);
`ifdef DISTANCE_WRAP_EN
    localparam logic        c_wrap_en  = 1'b1;
`else
    localparam logic        c_wrap_en  = 1'b0;
`endif

    state_t      r_state;
    logic [9:0]  r_frac;
    logic [15:0] r_bcd;
    logic        r_tick;
    logic        r_goal;

    state_t      w_state_nxt;
    logic [9:0]  w_frac_nxt;
    logic [15:0] w_bcd_nxt;
    logic        w_tick_nxt;
    logic        w_goal_nxt;

    logic [10:0] w_sum;
    logic        w_overflow;
    logic [9:0]  w_frac_wrap;
    logic [15:0] w_inc_bcd;
    logic [4:0]  w_carry;
    logic        w_can_inc;

    // Sum is 11 bits wide: 1022 + 255 exceeds the 10-bit accumulator.
    assign w_sum       = {1'b0, r_frac} + {3'b000, bus.speed};
    assign w_overflow  = (w_sum >= c_frac_max);
    assign w_frac_wrap = 10'(w_sum - c_frac_max);

    assign w_carry[0] = 1'b1;
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [3:0] w_d;
        assign w_d = r_bcd[4*gi +: 4];
        assign w_inc_bcd[4*gi +: 4] = !w_carry[gi]    ? w_d  :
                                      (w_d == 4'd9)   ? 4'd0 :
                                                        w_d + 4'd1;
        assign w_carry[gi+1] = w_carry[gi] & (w_d == 4'd9);
    end

    // Carry out of the top digit means the count currently reads 9999.
    assign w_can_inc = c_wrap_en | ~w_carry[4];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_frac  <= 10'd0;
            r_bcd   <= 16'h0000;
            r_tick  <= 1'b0;
            r_goal  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_frac  <= w_frac_nxt;
            r_bcd   <= w_bcd_nxt;
            r_tick  <= w_tick_nxt;
            r_goal  <= w_goal_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frac_nxt  = r_frac;
        w_bcd_nxt   = r_bcd;
        w_tick_nxt  = 1'b0;
        w_goal_nxt  = r_goal;

        if (bus.clear) begin
            w_state_nxt = IDLE;
            w_frac_nxt  = 10'd0;
            w_bcd_nxt   = 16'h0000;
            w_goal_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.run) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    // Dropping run pauses the race; no frame is counted on that edge.
                    if (!bus.run) begin
                        w_state_nxt = IDLE;
                    end else if (bus.startOfFrame) begin
                        if (w_overflow) begin
                            w_frac_nxt = w_frac_wrap;
                            if (w_can_inc) begin
                                w_bcd_nxt  = w_inc_bcd;
                                w_tick_nxt = 1'b1;
                                if (w_inc_bcd == GOAL) begin
                                    w_goal_nxt  = 1'b1;
                                    w_state_nxt = DONE;
                                end
                            end
                        end else begin
                            w_frac_nxt = w_sum[9:0];
                        end
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.thousands    = r_bcd[15:12];
    assign bus.hundreds     = r_bcd[11:8];
    assign bus.tens         = r_bcd[7:4];
    assign bus.units        = r_bcd[3:0];
    assign bus.distanceTick = r_tick;
    assign bus.goalReached  = r_goal;

endmodule
`default_nettype wire
